// File: rtl/esfa_op_sequencer_if.sv
// Host command/response channel plus array and
// combinator-root buses of the ESFA op sequencer.
interface esfa_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_op;
  logic [7:0] cmd_value;
  logic [7:0] cmd_context;

  logic [7:0] array_selector;
  logic [7:0] array_value;
  logic [7:0] array_context;
  logic       array_strobe;

  logic [7:0] root_value;
  logic [7:0] root_context;
  logic       root_bool;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_op;
  logic [7:0] rsp_value;
  logic [7:0] rsp_context;
  logic       rsp_found;

  logic       busy;
  logic       err_illegal;

  modport slave (
    input  cmd_valid, cmd_op, cmd_value,
    input  cmd_context,
    output cmd_ready,
    output array_selector, array_value,
    output array_context, array_strobe,
    input  root_value, root_context, root_bool,
    output rsp_valid, rsp_op, rsp_value,
    output rsp_context, rsp_found,
    input  rsp_ready,
    output busy, err_illegal
  );

  modport master (
    output cmd_valid, cmd_op, cmd_value,
    output cmd_context,
    input  cmd_ready,
    input  array_selector, array_value,
    input  array_context, array_strobe,
    output root_value, root_context, root_bool,
    input  rsp_valid, rsp_op, rsp_value,
    input  rsp_context, rsp_found,
    output rsp_ready,
    input  busy, err_illegal
  );
endinterface

// File: rtl/esfa_op_sequencer.sv
// Sequences host commands onto the ESFA array,
// expanding lookup/encode into two array phases.
module esfa_op_sequencer #(
  parameter int TREE_LATENCY = 3
) (
  input logic clk,
  input logic rst_n,
  esfa_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ISSUE2,
    S_WAIT2,
    S_RESP
  } state_t;

  // Strobe cycle counts as the first latency cycle,
  // so the counter starts one short.
  localparam logic [3:0] LOAD =
    4'(TREE_LATENCY - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_op;
  logic [7:0] r_sel;
  logic [7:0] r_val;
  logic [7:0] r_ctx;
  logic       r_strobe;
  logic [7:0] r_rsp_value;
  logic [7:0] r_rsp_context;
  logic       r_rsp_found;
  logic       r_err;

  logic w_illegal;
  logic w_two;
  logic w_void;
  logic w_hit;
  logic w_miss;

  assign w_illegal = bus.cmd_op > 8'd7;
  assign w_two  = (r_op == 8'd1) ||
                  (r_op == 8'd3);
  assign w_void = (r_op == 8'd5) ||
                  (r_op == 8'd6);
  assign w_hit  = w_two && bus.root_bool;
  assign w_miss = w_two && !bus.root_bool;

  assign bus.cmd_ready =
    rst_n && (r_state == S_IDLE);
  assign bus.busy      = r_state != S_IDLE;
  assign bus.rsp_valid = r_state == S_RESP;

  assign bus.array_selector = r_sel;
  assign bus.array_value    = r_val;
  assign bus.array_context  = r_ctx;
  assign bus.array_strobe   = r_strobe;
  assign bus.rsp_op         = r_op;
  assign bus.rsp_value      = r_rsp_value;
  assign bus.rsp_context    = r_rsp_context;
  assign bus.rsp_found      = r_rsp_found;
  assign bus.err_illegal    = r_err;

  // Sequencer FSM with registered array/response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_op          <= 8'd0;
      r_sel         <= 8'd0;
      r_val         <= 8'd0;
      r_ctx         <= 8'd0;
      r_strobe      <= 1'b0;
      r_rsp_value   <= 8'd0;
      r_rsp_context <= 8'd0;
      r_rsp_found   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_err    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_op <= bus.cmd_op;
            if (w_illegal) begin
              r_err         <= 1'b1;
              r_rsp_value   <= 8'd0;
              r_rsp_context <= 8'd0;
              r_rsp_found   <= 1'b0;
              r_state       <= S_RESP;
            end else begin
              // Encode first scans for a free cell
              r_sel    <= (bus.cmd_op == 8'd3) ?
                          8'd7 : bus.cmd_op;
              r_val    <= bus.cmd_value;
              r_ctx    <= bus.cmd_context;
              r_strobe <= 1'b1;
              r_state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= LOAD;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            unique case (1'b1)
              w_hit: begin
                // Second phase targets the hit cell
                r_sel    <= (r_op == 8'd1) ?
                            8'd2 : 8'd3;
                r_ctx    <= bus.root_context;
                r_strobe <= 1'b1;
                r_state  <= S_ISSUE2;
              end
              w_miss, w_void: begin
                r_rsp_value   <= 8'd0;
                r_rsp_context <= 8'd0;
                r_rsp_found   <= 1'b0;
                r_state       <= S_RESP;
              end
              default: begin
                r_rsp_value   <= bus.root_value;
                r_rsp_context <= bus.root_context;
                r_rsp_found   <= bus.root_bool;
                r_state       <= S_RESP;
              end
            endcase
          end
        end
        S_ISSUE2: begin
          r_cnt   <= LOAD;
          r_state <= S_WAIT2;
        end
        S_WAIT2: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_value   <= bus.root_value;
            r_rsp_context <= bus.root_context;
            r_rsp_found   <= bus.root_bool;
            r_state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esfa_op_sequencer.sv
// Self-checking bench for esfa_op_sequencer:
// directed test-plan steps plus random commands.
module tb_esfa_op_sequencer;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  esfa_op_sequencer_if bus();

  esfa_op_sequencer #(.TREE_LATENCY(L)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] m_sel = 8'd0;
  logic [7:0] m_val = 8'd0;
  logic [7:0] m_ctx = 8'd0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic root_rand;
    bus.root_value   = 8'($urandom);
    bus.root_context = 8'($urandom);
    bus.root_bool    = 1'($urandom);
  endtask

  task automatic chk_array;
    chk("array_selector", bus.array_selector, m_sel);
    chk("array_value", bus.array_value, m_val);
    chk("array_context", bus.array_context, m_ctx);
  endtask

  // Issue one command, model its array phases and
  // response, then apply bp cycles of backpressure.
  task automatic run_cmd(
    input logic [7:0] op, val, ctx,
    input logic [7:0] r1v, r1c, input logic r1b,
    input logic [7:0] r2v, r2c, input logic r2b,
    input int bp);
    bit illegal, two, zero;
    int samp1, s2, samp2, rsp_off;
    logic [7:0] ev, ec;
    logic ef;
    illegal = op > 8'd7;
    two = !illegal && (op == 8'd1 || op == 8'd3)
          && r1b;
    zero = illegal || op == 8'd5 || op == 8'd6 ||
           ((op == 8'd1 || op == 8'd3) && !r1b);
    samp1 = 1 + L;
    s2 = 2 + L;
    samp2 = 2 + 2 * L;
    rsp_off = illegal ? 1 : (two ? 3 + 2 * L : 2 + L);
    if (zero) begin
      ev = 8'd0; ec = 8'd0; ef = 1'b0;
    end else if (two) begin
      ev = r2v; ec = r2c; ef = r2b;
    end else begin
      ev = r1v; ec = r1c; ef = r1b;
    end

    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = op;
    bus.cmd_value   = val;
    bus.cmd_context = ctx;
    root_rand();
    for (int k = 1; k <= rsp_off; k++) begin
      tick();
      bus.cmd_valid = 1'($urandom);
      bus.cmd_op    = 8'($urandom_range(0, 7));
      if (k == 1 && !illegal) begin
        m_sel = (op == 8'd3) ? 8'd7 : op;
        m_val = val;
        m_ctx = ctx;
      end
      if (two && k == s2) begin
        m_sel = (op == 8'd1) ? 8'd2 : 8'd3;
        m_ctx = r1c;
      end
      chk("array_strobe", bus.array_strobe,
          32'((!illegal && k == 1) ||
              (two && k == s2)));
      chk_array();
      chk("err_illegal", bus.err_illegal,
          32'(illegal && k == 1));
      chk("rsp_valid", bus.rsp_valid,
          32'(k == rsp_off));
      chk("busy", bus.busy, 1);
      chk("cmd_ready_busy", bus.cmd_ready, 0);
      if (k == samp1) begin
        bus.root_value   = r1v;
        bus.root_context = r1c;
        bus.root_bool    = r1b;
      end else if (two && k == samp2) begin
        bus.root_value   = r2v;
        bus.root_context = r2c;
        bus.root_bool    = r2b;
      end else begin
        root_rand();
      end
    end

    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 8'($urandom_range(0, 7));
    for (int i = 0; i <= bp; i++) begin
      if (i > 0) begin
        tick();
        root_rand();
        chk("bp_rsp_valid", bus.rsp_valid, 1);
        chk("bp_cmd_ready", bus.cmd_ready, 0);
        chk("bp_strobe", bus.array_strobe, 0);
        chk("bp_err", bus.err_illegal, 0);
        chk_array();
      end
      chk("rsp_op", bus.rsp_op, op);
      chk("rsp_value", bus.rsp_value, ev);
      chk("rsp_context", bus.rsp_context, ec);
      chk("rsp_found", bus.rsp_found, ef);
    end

    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("idle_rsp_valid", bus.rsp_valid, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_cmd_ready", bus.cmd_ready, 1);
    chk("idle_strobe", bus.array_strobe, 0);
    chk_array();
  endtask

  initial begin
    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = 8'd0;
    bus.cmd_value    = 8'd0;
    bus.cmd_context  = 8'd0;
    bus.root_value   = 8'd0;
    bus.root_context = 8'd0;
    bus.root_bool    = 1'b0;
    bus.rsp_ready    = 1'b0;

    // reset values
    tick();
    tick();
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_strobe", bus.array_strobe, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_err", bus.err_illegal, 0);
    chk("rst_rsp_op", bus.rsp_op, 0);
    chk("rst_rsp_value", bus.rsp_value, 0);
    chk("rst_rsp_found", bus.rsp_found, 0);
    chk_array();
    rst_n = 1'b1;
    tick();
    chk("rel_cmd_ready", bus.cmd_ready, 1);

    // update
    run_cmd(8'd0, 8'h11, 8'h22,
            8'h11, 8'h22, 1'b1,
            8'h00, 8'h00, 1'b0, 0);
    // lookup hit
    run_cmd(8'd1, 8'h05, 8'h44,
            8'h5a, 8'h09, 1'b1,
            8'h33, 8'h09, 1'b1, 0);
    // encode on a full array
    run_cmd(8'd3, 8'h77, 8'h66,
            8'h12, 8'h34, 1'b0,
            8'hff, 8'hff, 1'b1, 0);
    // encode hit
    run_cmd(8'd3, 8'h78, 8'h01,
            8'h00, 8'h2c, 1'b1,
            8'h78, 8'h2c, 1'b1, 1);
    // void op
    run_cmd(8'd5, 8'h01, 8'h02,
            8'hab, 8'hcd, 1'b1,
            8'h00, 8'h00, 1'b0, 0);
    // illegal op
    run_cmd(8'h0a, 8'h99, 8'h88,
            8'h00, 8'h00, 1'b0,
            8'h00, 8'h00, 1'b0, 0);
    // long backpressure
    run_cmd(8'd4, 8'h3c, 8'h4d,
            8'hc3, 8'hd4, 1'b1,
            8'h00, 8'h00, 1'b0, 10);

    // random commands
    for (int n = 0; n < 40; n++) begin
      logic [7:0] op;
      if ($urandom_range(0, 9) == 9)
        op = 8'($urandom_range(8, 255));
      else
        op = 8'($urandom_range(0, 7));
      run_cmd(op, 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom),
              1'($urandom),
              8'($urandom), 8'($urandom),
              1'($urandom),
              int'($urandom_range(0, 3)));
    end

    // reset during WAIT2 of a lookup hit
    chk("wr_cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_op      = 8'd1;
    bus.cmd_value   = 8'h42;
    bus.cmd_context = 8'h24;
    root_rand();
    for (int k = 1; k <= 4 + L; k++) begin
      tick();
      bus.cmd_valid = 1'b0;
      if (k == 2 + L)
        chk("wr_strobe2", bus.array_strobe, 1);
      if (k == 1 + L) begin
        bus.root_value   = 8'h10;
        bus.root_context = 8'h20;
        bus.root_bool    = 1'b1;
      end else begin
        root_rand();
      end
    end
    chk("wr_busy", bus.busy, 1);
    chk("wr_sel2", bus.array_selector, 8'd2);
    rst_n = 1'b0;
    tick();
    m_sel = 8'd0;
    m_val = 8'd0;
    m_ctx = 8'd0;
    chk("ar_strobe", bus.array_strobe, 0);
    chk("ar_rsp_valid", bus.rsp_valid, 0);
    chk("ar_rsp_op", bus.rsp_op, 0);
    chk("ar_rsp_value", bus.rsp_value, 0);
    chk("ar_rsp_context", bus.rsp_context, 0);
    chk("ar_rsp_found", bus.rsp_found, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_err", bus.err_illegal, 0);
    chk("ar_cmd_ready", bus.cmd_ready, 0);
    chk_array();
    rst_n = 1'b1;
    for (int k = 0; k < 2 * L + 6; k++) begin
      tick();
      root_rand();
      chk("post_strobe", bus.array_strobe, 0);
      chk("post_rsp_valid", bus.rsp_valid, 0);
      chk("post_busy", bus.busy, 0);
      chk("post_cmd_ready", bus.cmd_ready, 1);
      chk_array();
    end

    // sequencer still works after the abort
    run_cmd(8'd2, 8'h0f, 8'hf0,
            8'h5e, 8'he5, 1'b1,
            8'h00, 8'h00, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
